// File: rtl/rst_out_sequencer_pkg.sv
// Shared reset-sequencing constants: FSM state encodings and reset cause codes,
// also meant for the reset input debouncer and the status register block.
package rst_out_sequencer_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ASSERT  = 2'd1;
    localparam logic [1:0] ST_HOLDOFF = 2'd2;

    localparam logic [1:0] RST_CAUSE_NONE = 2'b00;
    localparam logic [1:0] RST_CAUSE_POR  = 2'b01;
    localparam logic [1:0] RST_CAUSE_SOFT = 2'b10;
    localparam logic [1:0] RST_CAUSE_WDT  = 2'b11;

endpackage

// File: rtl/rst_out_sequencer.sv
// Turns soft-reset / watchdog requests into a fixed-width active-low external reset
// pulse followed by a holdoff window. Define RST_CAUSE_EN to keep a sticky reset-cause register.
module rst_out_sequencer
    import rst_out_sequencer_pkg::*;
#(
    parameter int ASSERT_CYCLES  = 4096,
    parameter int HOLDOFF_CYCLES = 256,
    parameter int CNT_W          = 12
) (
    input  logic       clk,
    input  logic       rst_n_i,
    input  logic       req_i,
    input  logic       wdt_i,
    output logic       req_ack_o,
    output logic       ext_rst_n_o,
    output logic       busy_o,
    output logic [1:0] cause_o,
    input  logic       cause_clr_i
);

    localparam logic [CNT_W-1:0] ASSERT_LOAD  = CNT_W'(ASSERT_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLDOFF_LOAD = CNT_W'(HOLDOFF_CYCLES - 1);

    logic [1:0]       state;
    logic [1:0]       state_next;
    logic [CNT_W-1:0] cnt;
    logic             cnt_zero;
    logic             req_q;
    logic             trigger;

    assign cnt_zero = (cnt == '0);
    // Only IDLE listens; edges seen while busy are simply lost.
    assign trigger  = (state == ST_IDLE) && ((req_i && !req_q) || wdt_i);

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:    if (trigger)  state_next = ST_ASSERT;
            ST_ASSERT:  if (cnt_zero) state_next = ST_HOLDOFF;
            ST_HOLDOFF: if (cnt_zero) state_next = ST_IDLE;
            default:                  state_next = ST_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state flop.
    always_ff @(posedge clk or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state       <= ST_ASSERT;
            ext_rst_n_o <= 1'b0;
            busy_o      <= 1'b1;
            req_ack_o   <= 1'b0;
        end else begin
            state       <= state_next;
            ext_rst_n_o <= (state_next != ST_ASSERT);
            busy_o      <= (state_next != ST_IDLE);
            req_ack_o   <= trigger;
        end
    end

    always_ff @(posedge clk or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt <= ASSERT_LOAD;
        end else if (trigger) begin
            cnt <= ASSERT_LOAD;
        end else if (state == ST_ASSERT && cnt_zero) begin
            cnt <= HOLDOFF_LOAD;
        end else if (state != ST_IDLE && !cnt_zero) begin
            cnt <= cnt - 1'b1;
        end
    end

    // Reset value 1 stops a request held high through reset from counting as an edge.
    always_ff @(posedge clk or negedge rst_n_i) begin
        if (!rst_n_i) begin
            req_q <= 1'b1;
        end else begin
            req_q <= req_i;
        end
    end

`ifdef RST_CAUSE_EN
    always_ff @(posedge clk or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cause_o <= RST_CAUSE_POR;
        end else if (trigger) begin
            cause_o <= wdt_i ? RST_CAUSE_WDT : RST_CAUSE_SOFT;
        end else if (cause_clr_i) begin
            cause_o <= RST_CAUSE_NONE;
        end
    end
`else
    logic unused_cause_clr;
    assign unused_cause_clr = cause_clr_i;
    assign cause_o          = RST_CAUSE_NONE;
`endif

endmodule
